// File: rtl/mem_responder.sv
// Byte-addressed memory responder for the Enable/ReadWrite/MOC handshake.
// Big-endian byte, halfword and word accesses; each request completes after
// LATENCY wait cycles plus one cycle per byte, then holds MOC until Enable drops.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic                  ReadWrite,
  input  logic [1:0]            Size,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  Err
);

  localparam int unsigned CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LM1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CW-1:0] WINIT = CW'(LM1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [1:0]            last_q;
  logic                  bad_q;
  logic [31:0]           din_q;
  logic [CW-1:0]         wcnt_q;
  logic [1:0]            idx_q;
  logic [31:0]           dout_q;
  logic                  moc_q;
  logic                  err_q;

  logic [7:0] Mem [0:2**ADDR_WIDTH-1];

  logic                  req_valid;
  logic [1:0]            req_last;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [1:0]            lane;
  logic                  mem_we;
  logic [7:0]            mem_wdata;

  // Request decode, current byte address and big-endian lane selection
  always_comb begin
    req_valid = (Size == 2'b00) ||
                (Size == 2'b01 && !Address[0]) ||
                (Size == 2'b10 && Address[1:0] == 2'b00);
    case (Size)
      2'b01:   req_last = 2'd1;
      2'b10:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
    byte_addr = addr_q + ADDR_WIDTH'(idx_q);
    lane      = last_q - idx_q;
    mem_we    = (state_q == XFER) && !rw_q && !reset;
    mem_wdata = din_q[{lane, 3'b000} +: 8];
  end

  // Byte storage; no reset so contents survive an aborted operation
  always_ff @(posedge clk) begin
    if (mem_we) Mem[byte_addr] <= mem_wdata;
  end

  // Request FSM with registered DataOut/MOC/Err
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      last_q  <= '0;
      bad_q   <= 1'b0;
      din_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable) begin
            addr_q <= Address;
            rw_q   <= ReadWrite;
            last_q <= req_last;
            bad_q  <= !req_valid;
            din_q  <= DataIn;
            dout_q <= '0;
            err_q  <= 1'b0;
            idx_q  <= '0;
            wcnt_q <= WINIT;
            if (!req_valid)       state_q <= DONE;
            else if (LATENCY > 0) state_q <= WAIT;
            else                  state_q <= XFER;
          end
        end
        WAIT: begin
          if (wcnt_q == '0) state_q <= XFER;
          else              wcnt_q  <= wcnt_q - CW'(1);
        end
        XFER: begin
          if (rw_q) dout_q[{lane, 3'b000} +: 8] <= Mem[byte_addr];
          if (idx_q == last_q) begin
            state_q <= DONE;
            moc_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        DONE: begin
          // Rejected requests enter DONE with MOC low and raise it one edge
          // later, so the one-cycle MOC pulse still holds if Enable is gone.
          if (!moc_q) begin
            moc_q <= 1'b1;
            err_q <= bad_q;
          end else if (!Enable) begin
            moc_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected results,
// a monitor checks them on every MOC rising edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Enable = 1'b0;
  logic        ReadWrite = 1'b1;
  logic [1:0]  Size = 2'b00;
  logic [8:0]  Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  mem_responder #(.ADDR_WIDTH(9), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .ReadWrite(ReadWrite),
    .Size(Size), .Address(Address), .DataIn(DataIn),
    .DataOut(DataOut), .MOC(MOC), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every MOC rising edge must match the oldest queued expectation
  logic moc_prev = 1'b0;
  always @(negedge clk) begin
    if (MOC && !moc_prev) begin
      if (sbq.size() == 0) begin
        check("unexpected_moc", 32'(MOC), 32'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_dataout", DataOut, e.dout);
        check("sb_err", 32'(Err), 32'(e.err));
      end
    end
    moc_prev = MOC;
  end

  // Issue one request; measure edges from accept to MOC, optionally hold
  // Enable in DONE for some cycles, then check MOC falls.
  task automatic do_req(input string nm, input logic rw, input logic [1:0] sz,
                        input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input bit pulse, input int hold);
    int lat;
    @(negedge clk);
    Enable = 1'b1; ReadWrite = rw; Size = sz; Address = a; DataIn = d;
    sbq.push_back('{dout: exp_d, err: exp_e});
    @(posedge clk);
    #1;
    if (pulse) begin
      Enable = 1'b0; ReadWrite = ~rw; Address = '1; DataIn = ~d;
    end
    lat = 0;
    for (int c = 1; c <= 50 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (MOC) lat = c;
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({nm, "_moc_held"}, 32'(MOC), 32'(1));
      check({nm, "_dout_stable"}, DataOut, exp_d);
    end
    if (pulse) begin
      @(posedge clk);
      #1;
      check({nm, "_moc_one_cycle"}, 32'(MOC), 32'(0));
    end else begin
      @(negedge clk);
      Enable = 1'b0;
      @(posedge clk);
      #1;
      check({nm, "_moc_fall"}, 32'(MOC), 32'(0));
    end
  endtask

  initial begin
    logic [7:0] exp_mem [0:7];
    for (int i = 0; i < 8; i++) dut.Mem[i] = 8'(8'h11 * (i + 1));
    for (int i = 8; i < 12; i++) dut.Mem[i] = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    check("reset_moc", 32'(MOC), 32'(0));
    check("reset_err", 32'(Err), 32'(0));
    check("reset_dout", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_req("word_read0", 1'b1, 2'b10, 9'd0, 32'h0, 32'h11223344, 1'b0, 6, 1'b0, 0);
    do_req("hw_write6", 1'b0, 2'b01, 9'd6, 32'h1234BEEF, 32'h0, 1'b0, 4, 1'b0, 0);
    check("mem6", 32'(dut.Mem[6]), 32'hBE);
    check("mem7", 32'(dut.Mem[7]), 32'hEF);
    do_req("byte_read6", 1'b1, 2'b00, 9'd6, 32'h0, 32'h000000BE, 1'b0, 3, 1'b0, 0);
    do_req("byte_read7", 1'b1, 2'b00, 9'd7, 32'h0, 32'h000000EF, 1'b0, 3, 1'b0, 0);

    do_req("bad_word2", 1'b1, 2'b10, 9'd2, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0);
    do_req("bad_size11", 1'b0, 2'b11, 9'd0, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b0, 0);
    do_req("bad_hw5", 1'b0, 2'b01, 9'd5, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b0, 0);
    exp_mem = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hBE, 8'hEF};
    for (int i = 0; i < 8; i++) check("mem_untouched", 32'(dut.Mem[i]), 32'(exp_mem[i]));

    do_req("pulse_wwrite", 1'b0, 2'b10, 9'h10, 32'hDEADBEEF, 32'h0, 1'b0, 6, 1'b1, 0);
    check("mem10", 32'(dut.Mem[16]), 32'hDE);
    check("mem11", 32'(dut.Mem[17]), 32'hAD);
    check("mem12", 32'(dut.Mem[18]), 32'hBE);
    check("mem13", 32'(dut.Mem[19]), 32'hEF);

    do_req("held_read", 1'b1, 2'b10, 9'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6, 1'b0, 10);
    do_req("reraise_read", 1'b1, 2'b00, 9'h13, 32'h0, 32'h000000EF, 1'b0, 3, 1'b0, 0);

    // Abort a word write after its second byte has been stored
    @(negedge clk);
    Enable = 1'b1; ReadWrite = 1'b0; Size = 2'b10; Address = 9'd8; DataIn = 32'hA1B2C3D4;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; Enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_moc", 32'(MOC), 32'(0));
    check("abort_dout", DataOut, 32'h0);
    check("abort_mem8", 32'(dut.Mem[8]), 32'hA1);
    check("abort_mem9", 32'(dut.Mem[9]), 32'hB2);
    check("abort_mem10", 32'(dut.Mem[10]), 32'h99);
    check("abort_mem11", 32'(dut.Mem[11]), 32'h99);
    @(negedge clk);
    reset = 1'b0;

    do_req("after_abort", 1'b1, 2'b10, 9'd8, 32'h0, 32'hA1B29999, 1'b0, 6, 1'b0, 0);
    do_req("hw_read12", 1'b1, 2'b01, 9'h12, 32'h0, 32'h0000BEEF, 1'b0, 4, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Clocked, byte-addressed memory responder for the processor's Enable/ReadWrite/MOC memory handshake. It accepts one request at a time from the memory initiator (CPU datapath or bench) and performs byte, halfword or word accesses in big-endian order. Each request completes after a programmable wait latency plus one cycle per byte. Completion is signalled by holding MOC high until the initiator drops Enable.

## Interface
- ADDR_WIDTH, 9, byte-address width; array `Mem` holds 2**ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles before the first byte transfer; 0 is legal.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  request strobe from the initiator; level-sensitive.
- ReadWrite  in  1  1 = read, 0 = write.
- Size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- Address  in  ADDR_WIDTH  byte address of the most significant byte.
- DataIn  in  32  write data; byte uses [7:0], halfword uses [15:0].
- DataOut  out  32  read data; zero-extended for byte and halfword.
- MOC  out  1  memory operation complete; registered.
- Err  out  1  request rejected (misaligned or reserved Size); valid while MOC=1.

## Operation
- Storage is `Mem[0 : 2**ADDR_WIDTH-1]`, 8 bits per entry.
  - Reset does not touch `Mem`.
  - Benches preload it hierarchically.
- FSM states are IDLE, WAIT, XFER and DONE.
- **IDLE**
  - Enable=1 accepts the request and latches Address, ReadWrite, Size and DataIn.
  - Accept also clears DataOut to 0 and Err to 0.
  - After accept, input changes are ignored until the FSM returns to IDLE.
- **Request validity**
  - Valid: Size=00; Size=01 with Address[0]=0; Size=10 with Address[1:0]=00.
  - Anything else is invalid. An invalid request goes IDLE→DONE with Err=1 and no memory access.
- **Valid request routing:** IDLE→WAIT if LATENCY>0, else IDLE→XFER.
- **WAIT:** lasts exactly LATENCY cycles, using a down-counter.
- **XFER:** lasts n cycles, where n = 1/2/4 for byte/halfword/word. Byte index i = 0..n-1 moves one byte per cycle at address A+i.
  - Read: `Mem[A+i]` goes to DataOut byte lane (n-1-i). A word read yields {M[A],M[A+1],M[A+2],M[A+3]}.
  - Write: DataIn byte lane (n-1-i) is written to `Mem[A+i]`.
  - A+i never carries out of the aligned unit, so no wrap-around is possible.
- **DONE**
  - MOC=1.
  - DataOut is stable.
  - Returns to IDLE on the first edge where Enable=0. MOC drops at that edge.
  - Enable held high keeps the FSM in DONE indefinitely; there is no re-trigger.
- **Enable dropped before DONE:** the operation still runs to completion. MOC is then high for exactly one cycle before IDLE.
- **Back-to-back requests:** a new request is accepted only in IDLE, so there is at least one cycle with MOC=0 between operations.
- **DataOut after a write:** remains 0.
- **DataOut after completion:** holds its value in IDLE until the next accept.

## Timing
- **Reset values:** state=IDLE, MOC=0, Err=0, DataOut=0, counter=0.
- **Reset mid-operation:** aborts at that edge. Bytes already written stay written. Outputs take their reset values.
- **reset vs Enable:** reset has priority over Enable in the same cycle.
- **Valid request accepted at edge k**
  - DONE is entered, and MOC=1, from edge k+LATENCY+n.
  - Example: word read with LATENCY=2 gives MOC=1 after edge k+6.
  - Byte read with LATENCY=0 gives MOC=1 after edge k+1.
- **Invalid request accepted at edge k:** MOC=1 and Err=1 after edge k+1.
- **DataOut during a read:** updated byte-by-byte during XFER. It is guaranteed final only while MOC=1.
- **Write visibility:** each byte is written to `Mem` at the edge ending its XFER cycle.
- **MOC fall:** if Enable falls in cycle c while in DONE, MOC=0 after the next edge.

## Test plan
- Preload `Mem[0..7]` = 8'h11..8'h88; word read at Address 0, LATENCY=2 -> MOC rises 6 cycles after accept, DataOut=32'h11223344, Err=0.
- Halfword write DataIn=32'hxxxxBEEF at Address 6, then byte reads at 6 and 7 -> DataOut=32'h000000BE and 32'h000000EF.
- Word read at Address 2, then Size=11 at Address 0 -> each gives MOC and Err=1 one cycle after accept, with DataOut=0 and `Mem` unchanged.
- Enable pulsed for 1 cycle on a word write -> all 4 bytes written, MOC high exactly one cycle, FSM back in IDLE.
- Enable held high through DONE for 10 cycles -> MOC stays 1 and no second access occurs; drop Enable -> MOC=0 next edge; re-raise Enable -> new accept.
- reset asserted during XFER of a word write at Address 8 after 2 bytes -> `Mem[8..9]` updated, `Mem[10..11]` unchanged, MOC=0, DataOut=0; next request completes normally.
